grayscale_wb_buffer: RTL and testbench

- Write-back elastic buffer directly downstream of the grayscale compute stage and upstream of the requestor's C1 write path.
- Grayscale emits one 512-bit line per valid with no backpressure; this block absorbs results while C1 is almost-full.
- Guarantees no overflow with read-credit accounting: the requestor issues a C0 read only while credits remain.

---
 rtl/grayscale_pkg.sv | 10 +
 rtl/grayscale_wb_ram.sv | 26 ++
 rtl/grayscale_wb_buffer.sv | 133 +++++++++++++
 tb/tb_grayscale_wb_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/grayscale_pkg.sv
// Shared types and sizing for the grayscale accelerator datapath.
package grayscale_pkg;

  localparam int unsigned HC_LINE_W   = 512;
  localparam int unsigned HC_WB_DEPTH = 64;
  localparam int unsigned HC_WB_CNT_W = $clog2(HC_WB_DEPTH) + 1;

  typedef logic [HC_LINE_W-1:0] t_hc_line;

endpackage

// File: rtl/grayscale_wb_ram.sv
// Simple dual-port line store for the write-back buffer: one write port,
// one read port with a registered 1-cycle read. The array is not reset.
module grayscale_wb_ram
  import grayscale_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [HC_LINE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [HC_LINE_W-1:0] rd_data
);

  localparam int unsigned ENTRIES = 1 << ADDR_W;

  logic [HC_LINE_W-1:0] mem [ENTRIES];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/grayscale_wb_buffer.sv
// Write-back elastic buffer between the grayscale stage and the C1 write
// path. A RAM of DEPTH-1 lines feeds a registered output stage; read credits
// bound the number of lines that can ever be in flight toward this buffer.
module grayscale_wb_buffer
  import grayscale_pkg::*;
#(
  parameter int unsigned DEPTH = HC_WB_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [HC_LINE_W-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 rd_issue,
  output logic                 credit_ok,
  output logic [CNT_W-1:0]     credits,
  output logic [HC_LINE_W-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNT_W-1:0]     level,
  output logic [31:0]          lines_out,
  output logic                 err_overflow,
  output logic                 err_credit
);

  localparam int unsigned     RAM_LINES = DEPTH - 1;
  localparam int unsigned     PTR_W     = $clog2(RAM_LINES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAM_LINES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  // Pointers wrap at exactly RAM_LINES, not at the power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q, rd_ptr_d;
  logic [HC_LINE_W-1:0] ram_rd_data, byp_data_q, head;
  logic                 byp_valid_q;
  logic [CNT_W-1:0]     ram_cnt, credits_d;
  logic                 pop, push, full, ram_empty, ram_pop, ram_push, ram_we;
  logic                 load_direct, overflow, credit_take, credit_err, byp_hit;

  // Datapath decisions for this cycle.
  always_comb begin
    pop         = valid_out && ready_in;
    full        = (level == DEPTH_C);
    push        = valid_in && (!full || pop);
    overflow    = valid_in && full && !pop;
    ram_cnt     = level - CNT_W'(valid_out);
    ram_empty   = (ram_cnt == '0);
    ram_pop     = pop && !ram_empty;
    load_direct = push && (!valid_out || (pop && ram_empty));
    ram_push    = push && !load_direct;
    ram_we      = ram_push && !clear;
    rd_ptr_d    = ram_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    // A line written to the address being read lands after the read samples.
    byp_hit     = ram_we && (wr_ptr_q == rd_ptr_d);
    head        = byp_valid_q ? byp_data_q : ram_rd_data;
    credit_take = rd_issue && (credits != '0);
    credit_err  = rd_issue && (credits == '0);
    credits_d   = credits - CNT_W'(credit_take) + CNT_W'(pop);
  end

  grayscale_wb_ram #(
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  // Output register, pointers and read-during-write bypass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out   <= 1'b0;
      data_out    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      byp_valid_q <= 1'b0;
      byp_data_q  <= '0;
    end else if (clear) begin
      valid_out   <= 1'b0;
      data_out    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      byp_valid_q <= 1'b0;
    end else begin
      if (load_direct) begin
        data_out  <= data_in;
        valid_out <= 1'b1;
      end else if (ram_pop) begin
        data_out  <= head;
      end else if (pop) begin
        valid_out <= 1'b0;
      end
      if (ram_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      rd_ptr_q    <= rd_ptr_d;
      byp_valid_q <= byp_hit;
      if (byp_hit) byp_data_q <= data_in;
    end
  end

  // Occupancy, credits, pop count and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level        <= '0;
      credits      <= DEPTH_C;
      credit_ok    <= 1'b1;
      lines_out    <= '0;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else if (clear) begin
      level        <= '0;
      credits      <= DEPTH_C;
      credit_ok    <= 1'b1;
      lines_out    <= '0;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      level     <= level + CNT_W'(push) - CNT_W'(pop);
      credits   <= credits_d;
      credit_ok <= (credits_d != '0);
      lines_out <= lines_out + 32'(pop);
      if (overflow)   err_overflow <= 1'b1;
      if (credit_err) err_credit   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grayscale_wb_buffer.sv
// Directed bench for grayscale_wb_buffer with a queue-based reference model.
module tb_grayscale_wb_buffer;
  import grayscale_pkg::*;

  localparam int unsigned DEPTH = HC_WB_DEPTH;
  localparam int unsigned CNT_W = HC_WB_CNT_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear = 1'b0;
  logic             valid_in = 1'b0;
  logic             rd_issue = 1'b0;
  logic             ready_in = 1'b0;
  t_hc_line         data_in = '0;
  logic             credit_ok, valid_out, err_overflow, err_credit;
  logic [CNT_W-1:0] credits, level;
  t_hc_line         data_out;
  logic [31:0]      lines_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  grayscale_wb_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .rd_issue     (rd_issue),
    .credit_ok    (credit_ok),
    .credits      (credits),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .level        (level),
    .lines_out    (lines_out),
    .err_overflow (err_overflow),
    .err_credit   (err_credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic t_hc_line line_of(input int i);
    t_hc_line l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'(i) ^ (32'h5A00_0000 + 32'(k));
    return l;
  endfunction

  // Reference model: a FIFO of lines plus plain counters.
  t_hc_line    mq[$];
  int          m_credits = int'(DEPTH);
  int unsigned m_lines   = 0;
  bit          m_ovf     = 1'b0;
  bit          m_cerr    = 1'b0;
  bit          m_pop, m_full;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      mq.delete();
      m_credits = int'(DEPTH);
      m_lines   = 0;
      m_ovf     = 1'b0;
      m_cerr    = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && ready_in;
      m_full = (mq.size() == int'(DEPTH));
      if (m_pop) begin
        void'(mq.pop_front());
        m_lines = m_lines + 1;
      end
      if (valid_in) begin
        if (!m_full || m_pop) mq.push_back(data_in);
        else m_ovf = 1'b1;
      end
      if (rd_issue) begin
        if (m_credits > 0) m_credits = m_credits - 1;
        else m_cerr = 1'b1;
      end
      if (m_pop) m_credits = m_credits + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("valid_out", 512'(valid_out), 512'(mq.size() != 0));
      check("level", 512'(level), 512'(mq.size()));
      check("credits", 512'(credits), 512'(m_credits));
      check("credit_ok", 512'(credit_ok), 512'(m_credits != 0));
      check("lines_out", 512'(lines_out), 512'(m_lines));
      check("err_overflow", 512'(err_overflow), 512'(m_ovf));
      check("err_credit", 512'(err_credit), 512'(m_cerr));
      if (mq.size() != 0) check("data_out", data_out, mq[0]);
    end
  end

  task automatic step(input logic vi, input t_hc_line d, input logic rdy,
                      input logic rdi, input logic clr);
    valid_in = vi;
    data_in  = d;
    ready_in = rdy;
    rd_issue = rdi;
    clear    = clr;
    @(negedge clk);
    valid_in = 1'b0;
    rd_issue = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic lit_reset_state(input string tag);
    check({tag, "_valid"}, 512'(valid_out), 512'(0));
    check({tag, "_data"}, data_out, 512'(0));
    check({tag, "_level"}, 512'(level), 512'(0));
    check({tag, "_credits"}, 512'(credits), 512'(64));
    check({tag, "_credit_ok"}, 512'(credit_ok), 512'(1));
    check({tag, "_lines"}, 512'(lines_out), 512'(0));
    check({tag, "_ovf"}, 512'(err_overflow), 512'(0));
    check({tag, "_cerr"}, 512'(err_credit), 512'(0));
  endtask

  t_hc_line a5 = {64{8'hA5}};

  initial begin
    // 1. Reset then idle.
    #2 reset_n = 1'b0;
    #1 lit_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    lit_reset_state("idle");

    // 2. Single line with 1-cycle latency, then pop.
    step(1'b1, a5, 1'b1, 1'b1, 1'b0);
    check("single_valid", 512'(valid_out), 512'(1));
    check("single_data", data_out, a5);
    check("single_credits", 512'(credits), 512'(63));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("single_level", 512'(level), 512'(0));
    check("single_lines", 512'(lines_out), 512'(1));
    check("single_credits_back", 512'(credits), 512'(64));

    // 3. Exhaust credits, credit error, fill to full.
    for (int i = 0; i < 64; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("drained_credits", 512'(credits), 512'(0));
    check("drained_credit_ok", 512'(credit_ok), 512'(0));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("cerr_set", 512'(err_credit), 512'(1));
    check("cerr_credits", 512'(credits), 512'(0));
    for (int i = 0; i < 64; i++) step(1'b1, line_of(i), 1'b0, 1'b0, 1'b0);
    check("full_level", 512'(level), 512'(64));
    check("full_head", data_out, line_of(0));

    // 4. Full with push and pop together.
    step(1'b1, line_of(100), 1'b1, 1'b0, 1'b0);
    check("fullpp_level", 512'(level), 512'(64));
    check("fullpp_ovf", 512'(err_overflow), 512'(0));
    check("fullpp_head", data_out, line_of(1));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Overflow while full and stalled.
    step(1'b1, line_of(200), 1'b0, 1'b0, 1'b0);
    check("ovf_set", 512'(err_overflow), 512'(1));
    check("ovf_level", 512'(level), 512'(64));
    check("ovf_head", data_out, line_of(1));

    // Drain in push order, one line per cycle.
    for (int i = 0; i < 64; i++) begin
      check("drain_order", data_out, (i < 63) ? line_of(i + 1) : line_of(100));
      check("drain_valid", 512'(valid_out), 512'(1));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    check("drain_level", 512'(level), 512'(0));
    check("drain_lines", 512'(lines_out), 512'(66));
    check("drain_credits", 512'(credits), 512'(64));

    // 5. Simultaneous rd_issue and pop at credits==10.
    for (int i = 0; i < 54; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, a5, 1'b0, 1'b0, 1'b0);
    check("c10_credits", 512'(credits), 512'(10));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("c10_same", 512'(credits), 512'(10));
    check("c10_lines", 512'(lines_out), 512'(67));

    // 6. Clear with level 5 and active push/pop/rd_issue.
    for (int i = 0; i < 5; i++) step(1'b1, line_of(300 + i), 1'b0, 1'b0, 1'b0);
    check("pre_clear_level", 512'(level), 512'(5));
    step(1'b1, line_of(400), 1'b1, 1'b1, 1'b1);
    lit_reset_state("clr");

    // Async reset mid-stream.
    for (int i = 0; i < 3; i++) step(1'b1, line_of(500 + i), 1'b1, 1'b1, 1'b0);
    check("stream_valid", 512'(valid_out), 512'(1));
    valid_in = 1'b1;
    data_in  = line_of(600);
    rd_issue = 1'b1;
    #2 reset_n = 1'b0;
    #1 lit_reset_state("arst");
    @(negedge clk);
    valid_in = 1'b0;
    rd_issue = 1'b0;
    reset_n  = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
